// File: rtl/fpu_io_bridge.sv
// Pad-side bridge for the fp16 core: gathers two 16-bit operands as nibble pairs,
// runs one start/done operation (with timeout), and returns the result as two bytes.
module fpu_io_bridge #(
   parameter int unsigned TIMEOUT = 15,
   parameter logic [15:0] ERR_VAL = 16'h7E00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] io_in,
   output logic [11:0] io_out,
   output logic [15:0] core_a,
   output logic [15:0] core_b,
   output logic        core_sel,
   output logic        core_start,
   input  logic        core_done,
   input  logic [15:0] core_result
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_HOLD  = 3'd4,
      S_TX_LO = 3'd5,
      S_TX_HI = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   a_q, a_d;
   logic [15:0]   b_q, b_d;
   logic          sel_q, sel_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   result_q, result_d;
   logic          err_q, err_d;
   logic [11:0]   io_out_q, io_out_d;
   logic          start_q, start_d;

   logic          in_en;
   logic          unused_io;

   assign in_en     = io_in[9];
   assign unused_io = ^io_in[11:10];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (in_en) begin
               a_d[3:0] = io_in[3:0];
               b_d[3:0] = io_in[7:4];
               sel_d    = io_in[8];
               err_d    = 1'b0;
               cnt_d    = 2'd1;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            // A dropped in_en mid-frame silently discards the partial operands.
            if (in_en) begin
               a_d[4*cnt_q +: 4] = io_in[3:0];
               b_d[4*cnt_q +: 4] = io_in[7:4];
               cnt_d             = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = S_ISSUE;
               end
            end else begin
               cnt_d   = 2'd0;
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) begin
               result_d = core_result;
               state_d  = S_HOLD;
            end else if (timer_q == TIMER_LAST) begin
               result_d = ERR_VAL;
               err_d    = 1'b1;
               state_d  = S_HOLD;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (!in_en) begin
               state_d = S_TX_LO;
            end
         end
         S_TX_LO: state_d = S_TX_HI;
         S_TX_HI: begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from next-state so the registered pins line up with the state.
   always_comb begin
      io_out_d     = '0;
      io_out_d[9]  = (state_d != S_IDLE);
      io_out_d[10] = err_d;
      if (state_d == S_TX_LO) begin
         io_out_d[8]   = 1'b1;
         io_out_d[7:0] = result_d[7:0];
      end else if (state_d == S_TX_HI) begin
         io_out_d[8]   = 1'b1;
         io_out_d[7:0] = result_d[15:8];
      end
      start_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sel_q    <= 1'b0;
         cnt_q    <= '0;
         timer_q  <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         io_out_q <= '0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         result_q <= result_d;
         err_q    <= err_d;
         io_out_q <= io_out_d;
         start_q  <= start_d;
      end
   end

   assign io_out     = io_out_q;
   assign core_a     = a_q;
   assign core_b     = b_q;
   assign core_sel   = sel_q;
   assign core_start = start_q;

endmodule

// File: tb/tb_fpu_io_bridge.sv
// Directed bench for fpu_io_bridge with a behavioural core that answers after a set latency.
module tb_fpu_io_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] io_in;
   logic [11:0] io_out;
   logic [15:0] core_a, core_b;
   logic        core_sel, core_start;
   logic        core_done;
   logic [15:0] core_result;

   int          n_cmp = 0;
   int          n_bad = 0;

   int          core_lat = 0;   // 0 = core never answers
   logic [15:0] core_val = '0;
   int          cd;

   fpu_io_bridge dut (
      .clock      (clock),
      .reset      (reset),
      .io_in      (io_in),
      .io_out     (io_out),
      .core_a     (core_a),
      .core_b     (core_b),
      .core_sel   (core_sel),
      .core_start (core_start),
      .core_done  (core_done),
      .core_result(core_result)
   );

   always #5 clock = ~clock;

   // done is raised in the core_lat-th WAIT cycle after the start pulse
   always @(posedge clock) begin
      if (reset) begin
         cd          <= 0;
         core_done   <= 1'b0;
         core_result <= 16'h0;
      end else if (core_start && core_lat > 0) begin
         cd          <= core_lat;
         core_done   <= (core_lat == 1);
         core_result <= (core_lat == 1) ? core_val : 16'hDEAD;
      end else if (cd > 0) begin
         cd          <= cd - 1;
         core_done   <= (cd == 2);
         core_result <= (cd == 2) ? core_val : 16'hDEAD;
      end else begin
         core_done   <= 1'b0;
         core_result <= 16'hDEAD;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic sel, input int nibbles);
      for (int i = 0; i < nibbles; i++) begin
         io_in = {2'b00, 1'b1, sel, b[4*i +: 4], a[4*i +: 4]};
         step();
      end
   endtask

   // Observe start pulses and the TX bytes; in_en drops at cycle index 'hold'.
   task automatic wait_tx(input int hold, output int starts, output int start_k, output int first_k,
                          output int nvalid, output logic [7:0] b0, output logic [7:0] b1,
                          output logic err_tx, output logic busy_after);
      starts = 0; start_k = -1; first_k = -1; nvalid = 0;
      b0 = 8'hxx; b1 = 8'hxx; err_tx = 1'bx; busy_after = 1'bx;
      for (int k = 0; k < 60; k++) begin
         if (k == hold) io_in = '0;
         if (core_start) begin
            starts++;
            start_k = k;
         end
         if (io_out[8]) begin
            if (nvalid == 0) begin
               b0 = io_out[7:0];
               first_k = k;
               err_tx = io_out[10];
            end else if (nvalid == 1) begin
               b1 = io_out[7:0];
            end
            nvalid++;
         end else if (nvalid > 0) begin
            busy_after = io_out[9];
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      io_in = '0;
      step();
      step();
      n_cmp++; if (io_out !== 12'h000) begin n_bad++; $display("FAIL reset_io_out: got %h want 000", io_out); end
      n_cmp++; if (core_a !== 16'h0) begin n_bad++; $display("FAIL reset_core_a: got %h want 0000", core_a); end
      n_cmp++; if (core_b !== 16'h0) begin n_bad++; $display("FAIL reset_core_b: got %h want 0000", core_b); end
      n_cmp++; if (core_sel !== 1'b0) begin n_bad++; $display("FAIL reset_core_sel: got %b want 0", core_sel); end
      n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL reset_core_start: got %b want 0", core_start); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_add();
      int s, sk, fk, nv; logic [7:0] b0, b1; logic e, bz;
      core_lat = 3; core_val = 16'h5451;
      send_frame(16'h5051, 16'h5051, 1'b1, 4);
      wait_tx(0, s, sk, fk, nv, b0, b1, e, bz);
      n_cmp++; if (core_a !== 16'h5051) begin n_bad++; $display("FAIL add_core_a: got %h want 5051", core_a); end
      n_cmp++; if (core_b !== 16'h5051) begin n_bad++; $display("FAIL add_core_b: got %h want 5051", core_b); end
      n_cmp++; if (core_sel !== 1'b1) begin n_bad++; $display("FAIL add_core_sel: got %b want 1", core_sel); end
      n_cmp++; if (s !== 1 || sk !== 0) begin n_bad++; $display("FAIL add_start: got %0d pulses at %0d want 1 at 0", s, sk); end
      n_cmp++; if (fk !== 5) begin n_bad++; $display("FAIL add_latency: got %0d want 5", fk); end
      n_cmp++; if (nv !== 2) begin n_bad++; $display("FAIL add_valid_cycles: got %0d want 2", nv); end
      n_cmp++; if (b0 !== 8'h51 || b1 !== 8'h54) begin n_bad++; $display("FAIL add_bytes: got %h,%h want 51,54", b0, b1); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL add_err: got %b want 0", e); end
      n_cmp++; if (bz !== 1'b0) begin n_bad++; $display("FAIL add_busy_after: got %b want 0", bz); end
   endtask

   task automatic test_abort();
      int s, sk, fk, nv; logic [7:0] b0, b1; logic e, bz;
      core_lat = 2; core_val = 16'h640E;
      send_frame(16'h1234, 16'h5678, 1'b1, 2);
      n_cmp++; if (io_out[9] !== 1'b1) begin n_bad++; $display("FAIL abort_busy_loading: got %b want 1", io_out[9]); end
      io_in = '0;
      step();
      n_cmp++; if (io_out[9] !== 1'b0) begin n_bad++; $display("FAIL abort_busy_drop: got %b want 0", io_out[9]); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (core_start !== 1'b0 || io_out[8] !== 1'b0) begin
            n_bad++; $display("FAIL abort_quiet: got start=%b valid=%b want 0,0", core_start, io_out[8]);
         end
         step();
      end
      send_frame(16'h5007, 16'h5007, 1'b0, 4);
      wait_tx(0, s, sk, fk, nv, b0, b1, e, bz);
      n_cmp++; if (core_sel !== 1'b0) begin n_bad++; $display("FAIL mul_core_sel: got %b want 0", core_sel); end
      n_cmp++; if (core_a !== 16'h5007 || core_b !== 16'h5007) begin n_bad++; $display("FAIL mul_operands: got %h,%h want 5007,5007", core_a, core_b); end
      n_cmp++; if (fk !== 4 || nv !== 2) begin n_bad++; $display("FAIL mul_timing: got first=%0d n=%0d want 4,2", fk, nv); end
      n_cmp++; if (b0 !== 8'h0E || b1 !== 8'h64) begin n_bad++; $display("FAIL mul_bytes: got %h,%h want 0e,64", b0, b1); end
   endtask

   task automatic test_timeout();
      int s, sk, fk, nv; logic [7:0] b0, b1; logic e, bz;
      core_lat = 0; core_val = 16'h1111;
      send_frame(16'h0001, 16'h0002, 1'b1, 4);
      wait_tx(0, s, sk, fk, nv, b0, b1, e, bz);
      // start at 0, 15 WAIT cycles, HOLD, then TX_LO
      n_cmp++; if (fk !== 17) begin n_bad++; $display("FAIL timeout_latency: got %0d want 17", fk); end
      n_cmp++; if (b0 !== 8'h00 || b1 !== 8'h7E) begin n_bad++; $display("FAIL timeout_bytes: got %h,%h want 00,7e", b0, b1); end
      n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL timeout_err_tx: got %b want 1", e); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (io_out[10] !== 1'b1) begin n_bad++; $display("FAIL timeout_err_sticky: got %b want 1", io_out[10]); end
         step();
      end
   endtask

   task automatic test_done_at_timeout();
      int s, sk, fk, nv; logic [7:0] b0, b1; logic e, bz;
      core_lat = 15; core_val = 16'h0000;
      send_frame(16'h00FF, 16'h0F0F, 1'b0, 1);
      n_cmp++; if (io_out[10] !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_frame: got %b want 0", io_out[10]); end
      io_in = {2'b00, 1'b1, 1'b0, 4'h0, 4'hF};
      step();
      io_in = {2'b00, 1'b1, 1'b0, 4'h0, 4'h0};
      step();
      io_in = {2'b00, 1'b1, 1'b0, 4'h0, 4'h0};
      step();
      wait_tx(0, s, sk, fk, nv, b0, b1, e, bz);
      n_cmp++; if (fk !== 17) begin n_bad++; $display("FAIL race_latency: got %0d want 17", fk); end
      n_cmp++; if (b0 !== 8'h00 || b1 !== 8'h00) begin n_bad++; $display("FAIL race_bytes: got %h,%h want 00,00", b0, b1); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL race_err: got %b want 0", e); end
   endtask

   task automatic test_held_in_en();
      int s, sk, fk, nv; logic [7:0] b0, b1; logic e, bz;
      core_lat = 1; core_val = 16'h4000;
      for (int h = 2; h <= 4; h += 2) begin
         send_frame(16'h3C00, 16'h3C00, 1'b1, 4);
         wait_tx(h, s, sk, fk, nv, b0, b1, e, bz);
         n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL held_starts: got %0d want 1 (hold %0d)", s, h); end
         n_cmp++; if (fk !== h + 1) begin n_bad++; $display("FAIL held_tx_start: got %0d want %0d", fk, h + 1); end
         n_cmp++; if (b0 !== 8'h00 || b1 !== 8'h40) begin n_bad++; $display("FAIL held_bytes: got %h,%h want 00,40", b0, b1); end
      end
   endtask

   task automatic test_reset_in_tx();
      int s, sk, fk, nv; logic [7:0] b0, b1; logic e, bz;
      int k;
      core_lat = 1; core_val = 16'hABCD;
      send_frame(16'h1234, 16'h4321, 1'b0, 4);
      io_in = '0;
      for (k = 0; k < 20; k++) begin
         if (io_out[8]) break;
         step();
      end
      n_cmp++; if (io_out[8] !== 1'b1 || io_out[7:0] !== 8'hCD) begin
         n_bad++; $display("FAIL rst_tx_lo: got valid=%b byte=%h want 1,cd", io_out[8], io_out[7:0]);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++; if (io_out !== 12'h000) begin n_bad++; $display("FAIL rst_tx_io_out: got %h want 000", io_out); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (io_out[8] !== 1'b0) begin n_bad++; $display("FAIL rst_tx_no_hi: got %b want 0", io_out[8]); end
      end
      core_lat = 2; core_val = 16'h3C00;
      send_frame(16'h3C00, 16'h3C00, 1'b0, 4);
      wait_tx(0, s, sk, fk, nv, b0, b1, e, bz);
      n_cmp++; if (nv !== 2 || b0 !== 8'h00 || b1 !== 8'h3C) begin
         n_bad++; $display("FAIL rst_next_frame: got n=%0d %h,%h want 2 00,3c", nv, b0, b1);
      end
   endtask

   initial begin
      reset = 1'b1;
      io_in = '0;
      test_reset();
      test_add();
      test_abort();
      test_timeout();
      test_done_at_timeout();
      test_held_in_en();
      test_reset_in_tx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
